// File: rtl/aui_am_scheduler.sv
// ---------------------------------------------------------------------------
// aui_am_scheduler
//
// Sequencing controller for the AUI lane generator datapath. Each beat it
// chooses whether the lane mux forwards payload, one half of an
// alignment-marker (AM) burst, or idle fill. It throttles the upstream source
// through a valid/ready handshake, honours downstream backpressure, and owns
// the AM insertion interval so the lane datapath needs no counters of its own.
//
// Optional feature (compile-time macro AUI_AM_IDLE_FILL_EN):
//   defined   - source gaps in DATA emit an idle-fill beat (o_sel = 11) that
//               counts toward the interval, so AM spacing is fixed in lane beats.
//   undefined - source gaps are bubbles (o_lane_valid = 0) and are not counted.
//
// Ports:
//   clk           clock
//   rst           asynchronous, active-high reset
//   i_enable      stream enable
//   i_interval    payload beats between AM bursts (0 is treated as 1)
//   i_src_valid   upstream payload valid
//   o_src_ready   upstream payload ready
//   i_sink_ready  lane datapath can accept a beat
//   o_lane_valid  beat presented to the lane datapath
//   o_sel         mux select: 00 payload, 01 AM beat0, 10 AM beat1, 11 idle fill
//   o_am_seq      completed AM bursts, modulo 2^AM_SEQ_WIDTH
//   o_data_cnt    beats counted in the current interval window
//   o_busy        high whenever the scheduler is not idle
// ---------------------------------------------------------------------------
module aui_am_scheduler #(
    parameter int INTERVAL_WIDTH   = 16,
    parameter int DEFAULT_INTERVAL = 20,
    parameter int AM_SEQ_WIDTH     = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_enable,
    input  logic [INTERVAL_WIDTH-1:0] i_interval,
    input  logic                      i_src_valid,
    output logic                      o_src_ready,
    input  logic                      i_sink_ready,
    output logic                      o_lane_valid,
    output logic [1:0]                o_sel,
    output logic [AM_SEQ_WIDTH-1:0]   o_am_seq,
    output logic [INTERVAL_WIDTH-1:0] o_data_cnt,
    output logic                      o_busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_AM0  = 2'd1;
    localparam logic [1:0] S_AM1  = 2'd2;
    localparam logic [1:0] S_DATA = 2'd3;

    localparam logic [1:0] SEL_PAYLOAD = 2'b00;
    localparam logic [1:0] SEL_AM0     = 2'b01;
    localparam logic [1:0] SEL_AM1     = 2'b10;
    localparam logic [1:0] SEL_FILL    = 2'b11;

    localparam logic [INTERVAL_WIDTH-1:0] CNT_ONE = INTERVAL_WIDTH'(1);
    localparam logic [AM_SEQ_WIDTH-1:0]   SEQ_ONE = AM_SEQ_WIDTH'(1);

    logic [1:0]                r_state;
    logic [1:0]                r_sel;
    logic                      r_busy;
    logic [AM_SEQ_WIDTH-1:0]   r_am_seq;
    logic [INTERVAL_WIDTH-1:0] r_data_cnt;
    logic [INTERVAL_WIDTH-1:0] r_interval;

    logic [1:0]                w_next_state;
    logic                      w_fill;
    logic                      w_beat;
    logic                      w_last;
    logic                      w_am1_done;
    logic [INTERVAL_WIDTH-1:0] w_interval_eff;

`ifdef AUI_AM_IDLE_FILL_EN
    // A source gap while the sink can accept becomes an idle-fill lane beat.
    assign w_fill = (r_state == S_DATA) && !i_src_valid && i_sink_ready;
`else
    assign w_fill = 1'b0;
`endif

    // A lane beat in DATA: either a payload transfer or an idle-fill beat.
    assign w_beat         = (r_state == S_DATA) && i_sink_ready && (i_src_valid || w_fill);
    // r_interval is never 0, so the subtraction cannot underflow.
    assign w_last         = (r_data_cnt == (r_interval - CNT_ONE));
    assign w_am1_done     = (r_state == S_AM1) && i_sink_ready;
    assign w_interval_eff = (i_interval == '0) ? CNT_ONE : i_interval;

    // NOTE: every signal written in always_comb gets a default first so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (i_enable)     w_next_state = S_AM0;
            S_AM0:  if (i_sink_ready) w_next_state = S_AM1;
            S_AM1:  if (i_sink_ready) w_next_state = i_enable ? S_DATA : S_IDLE;
            S_DATA: begin
                // Disable wins over the interval boundary; the burst is then
                // issued fresh on re-enable.
                if (!i_enable)             w_next_state = S_IDLE;
                else if (w_beat && w_last) w_next_state = S_AM0;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments and an asynchronous
    // reset, so every output returns to its reset value as soon as rst rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_sel      <= SEL_PAYLOAD;
            r_busy     <= 1'b0;
            r_am_seq   <= '0;
            r_data_cnt <= '0;
            r_interval <= INTERVAL_WIDTH'(DEFAULT_INTERVAL);
        end else begin
            r_state <= w_next_state;
            r_busy  <= (w_next_state != S_IDLE);
            case (w_next_state)
                S_AM0:   r_sel <= SEL_AM0;
                S_AM1:   r_sel <= SEL_AM1;
                default: r_sel <= SEL_PAYLOAD;
            endcase

            if (w_am1_done) begin
                r_am_seq   <= r_am_seq + SEQ_ONE;
                r_data_cnt <= '0;
                r_interval <= w_interval_eff;
            end else if ((r_state == S_IDLE) && i_enable) begin
                // A restarted stream never shows a stale window count.
                r_data_cnt <= '0;
            end else if (w_beat && !w_last) begin
                // The boundary beat leaves the count at interval-1 until the
                // AM1 handshake clears it.
                r_data_cnt <= r_data_cnt + CNT_ONE;
            end
        end
    end

    // Handshake outputs are combinational in DATA for zero-latency forwarding.
    always_comb begin
        o_src_ready  = 1'b0;
        o_lane_valid = 1'b0;
        case (r_state)
            S_AM0, S_AM1: o_lane_valid = 1'b1;
            S_DATA: begin
                o_src_ready  = i_sink_ready;
                o_lane_valid = i_src_valid || w_fill;
            end
            default: ;
        endcase
    end

    assign o_sel      = w_fill ? SEL_FILL : r_sel;
    assign o_busy     = r_busy;
    assign o_am_seq   = r_am_seq;
    assign o_data_cnt = r_data_cnt;

endmodule

// File: tb/tb_aui_am_scheduler.sv
// ---------------------------------------------------------------------------
// Self-checking bench for aui_am_scheduler. A cycle-level reference model
// describes the stream as "where are we in the burst / window" plus counts;
// every cycle all outputs are compared against it, and directed scenarios add
// explicit expectations for the interesting sequences.
// ---------------------------------------------------------------------------
module tb_aui_am_scheduler;

    localparam int IW = 16;
    localparam int SW = 4;

`ifdef AUI_AM_IDLE_FILL_EN
    localparam bit FILL = 1'b1;
`else
    localparam bit FILL = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          i_enable;
    logic [IW-1:0] i_interval;
    logic          i_src_valid;
    logic          o_src_ready;
    logic          i_sink_ready;
    logic          o_lane_valid;
    logic [1:0]    o_sel;
    logic [SW-1:0] o_am_seq;
    logic [IW-1:0] o_data_cnt;
    logic          o_busy;

    int n_checks = 0;
    int n_errors = 0;

    aui_am_scheduler #(
        .INTERVAL_WIDTH  (IW),
        .DEFAULT_INTERVAL(20),
        .AM_SEQ_WIDTH    (SW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_enable    (i_enable),
        .i_interval  (i_interval),
        .i_src_valid (i_src_valid),
        .o_src_ready (o_src_ready),
        .i_sink_ready(i_sink_ready),
        .o_lane_valid(o_lane_valid),
        .o_sel       (o_sel),
        .o_am_seq    (o_am_seq),
        .o_data_cnt  (o_data_cnt),
        .o_busy      (o_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // phase: 0 idle, 1 sending AM beat0, 2 sending AM beat1, 3 streaming data
    int m_phase;
    int m_bursts;     // total completed AM bursts (unwrapped)
    int m_window;     // beats counted in current window
    int m_interval;   // window length in force

    function automatic void model_reset();
        m_phase    = 0;
        m_bursts   = 0;
        m_window   = 0;
        m_interval = 20;
    endfunction

    task automatic model_compare();
        int  e_sel;
        bit  e_lv;
        bit  gap_fill;
        gap_fill = (m_phase == 3) && FILL && !i_src_valid && i_sink_ready;
        e_sel = (m_phase == 1) ? 1 : (m_phase == 2) ? 2 : gap_fill ? 3 : 0;
        e_lv  = (m_phase == 1) || (m_phase == 2) || ((m_phase == 3) && (i_src_valid || gap_fill));
        check("sel", 32'(o_sel), 32'(e_sel));
        check("lane_valid", 32'(o_lane_valid), 32'(e_lv));
        check("src_ready", 32'(o_src_ready), 32'((m_phase == 3) && i_sink_ready));
        check("busy", 32'(o_busy), 32'(m_phase != 0));
        check("am_seq", 32'(o_am_seq), 32'(m_bursts % 16));
        check("data_cnt", 32'(o_data_cnt), 32'(m_window));
    endtask

    function automatic void model_advance();
        bit beat;
        case (m_phase)
            0: if (i_enable) begin m_phase = 1; m_window = 0; end
            1: if (i_sink_ready) m_phase = 2;
            2: if (i_sink_ready) begin
                m_bursts++;
                m_window   = 0;
                m_interval = (i_interval == 0) ? 1 : int'(i_interval);
                m_phase    = i_enable ? 3 : 0;
            end
            default: begin
                beat = i_sink_ready && (i_src_valid || FILL);
                if (beat) begin
                    // window count saturates at interval-1; that beat closes it
                    if (m_window + 1 < m_interval) m_window = m_window + 1;
                    else if (i_enable) m_phase = 1;
                end
                if (!i_enable) m_phase = 0;
            end
        endcase
    endfunction

    // Inputs are set ~1 time unit after a rising edge; tick compares then
    // advances one clock, returning 1 time unit after the next rising edge.
    task automatic tick();
        #1;
        model_compare();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    task automatic reset_dut();
        rst          = 1'b1;
        i_enable     = 1'b0;
        i_src_valid  = 1'b0;
        i_sink_ready = 1'b0;
        i_interval   = '0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    int exp_t1[8] = '{1, 2, 0, 0, 0, 0, 1, 2};
    int exp_t3[9] = '{1, 2, 0, 1, 2, 0, 1, 2, 0};
    bit pat_t5[4] = '{1'b1, 1'b0, 1'b1, 1'b1};

    initial begin
        rst          = 1'b1;
        i_enable     = 1'b0;
        i_interval   = '0;
        i_src_valid  = 1'b0;
        i_sink_ready = 1'b0;
        #2;
        check("reset_sel", 32'(o_sel), 0);
        check("reset_busy", 32'(o_busy), 0);
        check("reset_lane_valid", 32'(o_lane_valid), 0);
        check("reset_am_seq", 32'(o_am_seq), 0);

        // 1: interval 4, everything flowing
        reset_dut();
        i_interval = 16'd4; i_enable = 1'b1; i_src_valid = 1'b1; i_sink_ready = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            check("t1_sel", 32'(o_sel), 32'(exp_t1[i]));
            if (i == 2) check("t1_am_seq_first", 32'(o_am_seq), 1);
            tick();
        end
        check("t1_am_seq_second", 32'(o_am_seq), 2);

        // 2: backpressure in AM0
        reset_dut();
        i_interval = 16'd2; i_enable = 1'b1; i_src_valid = 1'b1; i_sink_ready = 1'b1;
        tick();
        i_sink_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t2_hold_sel", 32'(o_sel), 1);
            check("t2_hold_src_ready", 32'(o_src_ready), 0);
            tick();
        end
        i_sink_ready = 1'b1;
        tick();
        check("t2_am1_sel", 32'(o_sel), 2);

        // 3: interval 0 behaves as 1
        reset_dut();
        i_interval = '0; i_enable = 1'b1; i_src_valid = 1'b1; i_sink_ready = 1'b1;
        tick();
        for (int i = 0; i < 9; i++) begin
            check("t3_sel", 32'(o_sel), 32'(exp_t3[i]));
            tick();
        end

        // 4: enable drops in AM0, burst still completes
        reset_dut();
        i_interval = 16'd3; i_enable = 1'b1; i_src_valid = 1'b1; i_sink_ready = 1'b1;
        tick();
        i_enable = 1'b0;
        tick();
        check("t4_am1_sel", 32'(o_sel), 2);
        tick();
        check("t4_idle_lane_valid", 32'(o_lane_valid), 0);
        check("t4_idle_busy", 32'(o_busy), 0);
        i_enable = 1'b1;
        tick();
        check("t4_restart_sel", 32'(o_sel), 1);
        check("t4_restart_cnt", 32'(o_data_cnt), 0);

        // 5: source gap: bubble vs idle fill
        reset_dut();
        i_interval = 16'd3; i_enable = 1'b1; i_src_valid = 1'b1; i_sink_ready = 1'b1;
        tick(); tick(); tick();
        for (int k = 0; k < 4; k++) begin
            i_src_valid = pat_t5[k];
            if (k == 1) begin
                #1;
                check("t5_gap_sel", 32'(o_sel), FILL ? 3 : 0);
                check("t5_gap_lane_valid", 32'(o_lane_valid), 32'(FILL));
            end
            tick();
            if (k == 2) check("t5_after3_sel", 32'(o_sel), FILL ? 1 : 0);
            if (k == 3) check("t5_after4_sel", 32'(o_sel), FILL ? 2 : 1);
        end

        // 6: asynchronous reset mid-DATA, then am_seq wrap
        reset_dut();
        i_interval = 16'd3; i_enable = 1'b1; i_src_valid = 1'b1; i_sink_ready = 1'b1;
        tick(); tick(); tick(); tick();
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_sel", 32'(o_sel), 0);
        check("t6_rst_lane_valid", 32'(o_lane_valid), 0);
        check("t6_rst_src_ready", 32'(o_src_ready), 0);
        check("t6_rst_busy", 32'(o_busy), 0);
        check("t6_rst_am_seq", 32'(o_am_seq), 0);
        check("t6_rst_cnt", 32'(o_data_cnt), 0);
        reset_dut();
        i_interval = 16'd1; i_enable = 1'b1; i_src_valid = 1'b1; i_sink_ready = 1'b1;
        begin
            int guard;
            guard = 0;
            while (m_bursts < 16 && guard < 200) begin
                tick();
                guard++;
            end
            check("t6_wrap_in_budget", 32'(guard < 200), 1);
        end
        check("t6_wrap_am_seq", 32'(o_am_seq), 0);

        // Randomized traffic against the model
        reset_dut();
        for (int c = 0; c < 3000; c++) begin
            i_enable     = ($urandom_range(0, 15) != 0);
            i_src_valid  = ($urandom_range(0, 3) != 0);
            i_sink_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) i_interval = IW'($urandom_range(0, 6));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/aui_am_scheduler.md
Name: aui_am_scheduler

Overview:
- Sequencing controller for the AUI lane generator datapath.
- Decides per beat whether the lane mux forwards payload, an alignment-marker (AM) beat, or idle fill.
- Throttles the upstream source with a valid/ready handshake and honours downstream backpressure.
- Owns the AM insertion interval, so the lane datapath carries no counters of its own.

Parameters:
- INTERVAL_WIDTH, 16, width of the interval and data-beat counters.
- DEFAULT_INTERVAL, 20, interval loaded at reset.
- AM_SEQ_WIDTH, 4, width of the AM burst sequence counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- i_enable  in  1  stream enable.
- i_interval  in  INTERVAL_WIDTH  payload beats between AM bursts; value 0 is treated as 1.
- i_src_valid  in  1  upstream payload valid.
- o_src_ready  out  1  upstream payload ready.
- i_sink_ready  in  1  lane datapath can accept a beat.
- o_lane_valid  out  1  beat presented to the lane datapath.
- o_sel  out  2  mux select: 00 payload, 01 AM beat0 (upper AM half plus padding), 10 AM beat1 (lower AM half), 11 idle fill.
- o_am_seq  out  AM_SEQ_WIDTH  completed AM bursts, modulo 2^AM_SEQ_WIDTH.
- o_data_cnt  out  INTERVAL_WIDTH  beats counted in the current interval window.
- o_busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; o_lane_valid=0, o_src_ready=0, o_sel=00, o_am_seq=0, o_data_cnt=0, o_busy=0.
  - Latched interval = DEFAULT_INTERVAL.
  - Outputs take these values immediately, without waiting for a clock edge.
- States: IDLE, AM0, AM1, DATA. Registered state; o_sel, o_busy and counters are registered. o_src_ready and o_lane_valid are combinational in DATA and constant in the other states.
- IDLE:
  - o_lane_valid=0, o_src_ready=0.
  - i_enable=1 → AM0. Every stream starts with an AM burst.
- AM0:
  - o_sel=01, o_lane_valid=1, o_src_ready=0.
  - i_sink_ready=1 → AM1; otherwise hold in AM0.
- AM1:
  - o_sel=10, o_lane_valid=1, o_src_ready=0.
  - On i_sink_ready=1: o_am_seq+1 (wraps), o_data_cnt←0, latch i_interval (0→1).
  - Next state is DATA if i_enable=1, else IDLE.
- DATA:
  - o_sel=00, o_src_ready=i_sink_ready, o_lane_valid=i_src_valid. Zero latency through this block.
  - A transfer occurs when i_src_valid and i_sink_ready are both 1; each transfer increments o_data_cnt.
  - A transfer with o_data_cnt == latched_interval−1 → AM0, with o_data_cnt cleared at the AM1 handshake.
- AM bursts are atomic:
  - Deasserting i_enable during AM0 or AM1 still completes both beats, then goes to IDLE.
  - In DATA, i_enable=0 → IDLE at the next edge. A transfer in that same cycle still completes and is counted.
  - Re-enabling from IDLE always begins with a fresh AM burst; o_data_cnt restarts at 0.
- i_interval changes take effect only at the AM1 handshake; the window in progress is unaffected.
- o_data_cnt never exceeds latched_interval−1.

Optional Feature:
- Macro: AUI_AM_IDLE_FILL_EN.
- Defined:
  - In DATA with i_src_valid=0 and i_sink_ready=1, the block emits an idle-fill beat: o_sel=11, o_lane_valid=1.
  - The fill beat counts toward the interval, so AM spacing is fixed in lane beats.
  - o_sel returns to 00 on the next cycle with i_src_valid=1.
- Undefined:
  - Source gaps produce bubbles: o_lane_valid=0, not counted.
  - The value 11 never appears on o_sel.

Test Plan:
1. Reset, i_interval=4, i_enable=1, src valid and sink ready held at 1 → o_sel sequence 01,10,00,00,00,00,01,10,…; o_am_seq 0→1 after the first AM1 and 1→2 after the second.
2. In AM0, i_sink_ready=0 for 3 cycles → o_sel holds 01 and o_src_ready=0 throughout; AM1 follows on the first cycle with ready=1.
3. i_interval=0 → o_sel repeats 01,10,00; each window allows exactly one payload transfer.
4. i_enable drops during AM0 → AM1 is still issued, then IDLE with o_lane_valid=0 and o_busy=0; re-enable → restarts at AM0 with o_data_cnt=0.
5. i_interval=3, sink always ready, i_src_valid pattern 1,0,1,1 → without the macro, AM0 follows after 4 cycles (3 transfers); with AUI_AM_IDLE_FILL_EN, the bubble shows o_sel=11 and AM0 follows after 3 cycles.
6. Assert rst mid-DATA between clock edges → all outputs read their reset values immediately. Run 16 complete AM bursts after release → o_am_seq wraps back to 0.
